// File: rtl/instr_sequencer_pkg.sv
// isa_pkg: opcodes, sequencer states, ram register map and instruction field layout.
package isa_pkg;

    typedef enum logic [3:0] {
        OP_NOP    = 4'h0,
        OP_MOVWF  = 4'h1,
        OP_MOVF   = 4'h2,
        OP_ADDWF  = 4'h3,
        OP_SUBWF  = 4'h4,
        OP_ANDWF  = 4'h5,
        OP_IORWF  = 4'h6,
        OP_XORWF  = 4'h7,
        OP_MOVLW  = 4'h8,
        OP_ADDLW  = 4'h9,
        OP_GOTO   = 4'hA,
        OP_CALL   = 4'hB,
        OP_RETURN = 4'hC,
        OP_SKPZ   = 4'hD,
        OP_SKPC   = 4'hE,
        OP_HALT   = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_READ,
        S_EXEC,
        S_WB,
        S_HALT
    } state_e;

    typedef enum logic [10:0] {
        REG_W    = 11'h200,
        REG_C    = 11'h201,
        REG_Z    = 11'h202,
        REG_INDF = 11'h203,
        REG_FSR  = 11'h204
    } ram_reg_e;

    localparam int OPC_LSB = 12;
    localparam int D_BIT   = 11;
    localparam int F_W     = 11;

    function automatic logic sets_c(opcode_e op);
        return op inside {OP_ADDWF, OP_SUBWF, OP_ADDLW};
    endfunction

    function automatic logic sets_z(opcode_e op);
        return op inside {OP_ADDWF, OP_SUBWF, OP_ADDLW, OP_MOVF,
                          OP_ANDWF, OP_IORWF, OP_XORWF};
    endfunction

    function automatic logic is_f_op(opcode_e op);
        return op inside {OP_MOVF, OP_ADDWF, OP_SUBWF,
                          OP_ANDWF, OP_IORWF, OP_XORWF};
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: sequencer <-> data ram / W register bus.
interface instr_sequencer_if;
    logic [10:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_write_enable;
    logic [15:0] mem_rdata;
    logic [15:0] wreg_wdata;
    logic        wreg_we;
    logic [15:0] wreg;
    logic        carry_cur;
    logic        zero_cur;
    logic        carry_next;
    logic        zero_next;

    modport master (
        output mem_addr, mem_wdata, mem_write_enable,
        output wreg_wdata, wreg_we, carry_next, zero_next,
        input  mem_rdata, wreg, carry_cur, zero_cur
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_write_enable,
        input  wreg_wdata, wreg_we, carry_next, zero_next,
        output mem_rdata, wreg, carry_cur, zero_cur
    );
endinterface

// File: rtl/instr_sequencer_seq_alu.sv
// seq_alu: combinational 16-bit datapath producing result, carry and zero.
module seq_alu
    import isa_pkg::*;
(
    input  opcode_e     op,
    input  logic [15:0] f,
    input  logic [15:0] w,
    input  logic [15:0] k,
    output logic [15:0] result,
    output logic        carry,
    output logic        zero
);

    logic [16:0] sum;

    always_comb begin
        sum    = '0;
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_MOVWF: result = w;
            OP_MOVF:  result = f;
            OP_ADDWF: begin
                sum    = {1'b0, f} + {1'b0, w};
                result = sum[15:0];
                carry  = sum[16];
            end
            OP_SUBWF: begin
                result = f - w;
                carry  = (f >= w);
            end
            OP_ANDWF: result = f & w;
            OP_IORWF: result = f | w;
            OP_XORWF: result = f ^ w;
            OP_MOVLW: result = k;
            OP_ADDLW: begin
                sum    = {1'b0, w} + {1'b0, k};
                result = sum[15:0];
                carry  = sum[16];
            end
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: fixed 5-cycle fetch/decode/read/exec/wb sequencer driving the data ram.
// Define CALL_STACK_EN to build the CALL/RETURN return stack.
module instr_sequencer
    import isa_pkg::*;
#(
    parameter int PC_W        = 11,
    parameter int STACK_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    output logic [PC_W-1:0]   prog_addr,
    input  logic [15:0]       prog_data,
    instr_sequencer_if.master bus,
    output logic              halted,
    output logic              stack_err
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, pc_inc, pc_nxt;
    logic [15:0]     ir_q, res_q, alu_res;
    logic            c_q, z_q, alu_c, alu_z;
    opcode_e         op;
    logic            d_f, in_wb, wr_f, wr_w, flag_hit;
    logic [F_W-1:0]  fld;

    assign op     = opcode_e'(ir_q[OPC_LSB +: 4]);
    assign d_f    = ir_q[D_BIT];
    assign fld    = ir_q[F_W-1:0];
    assign in_wb  = (state_q == S_WB);
    assign pc_inc = pc_q + 1'b1;

    seq_alu u_alu (
        .op     (op),
        .f      (bus.mem_rdata),
        .w      (bus.wreg),
        .k      (16'(fld)),
        .result (alu_res),
        .carry  (alu_c),
        .zero   (alu_z)
    );

    assign wr_f     = (op == OP_MOVWF) || (is_f_op(op) && d_f);
    assign wr_w     = (op inside {OP_MOVLW, OP_ADDLW}) || (is_f_op(op) && !d_f);
    // A direct write to the C/Z cells must not be overridden by the flag path.
    assign flag_hit = wr_f && (fld == REG_C || fld == REG_Z);

    assign prog_addr            = pc_q;
    assign bus.mem_addr         = fld;
    assign bus.mem_wdata        = res_q;
    assign bus.wreg_wdata       = res_q;
    assign bus.mem_write_enable = in_wb && wr_f;
    assign bus.wreg_we          = in_wb && wr_w;
    assign bus.carry_next = (in_wb && sets_c(op) && !flag_hit) ? c_q : bus.carry_cur;
    assign bus.zero_next  = (in_wb && sets_z(op) && !flag_hit) ? z_q : bus.zero_cur;
    assign halted = (state_q == S_HALT) || (in_wb && op == OP_HALT);

`ifdef CALL_STACK_EN
    localparam int SP_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [PC_W-1:0] stack_q [STACK_DEPTH];
    logic [SP_W-1:0] sp_q;
    logic [SP_W:0]   cnt_q;
    logic            err_q, push, pop;

    assign push      = in_wb && (op == OP_CALL);
    assign pop       = in_wb && (op == OP_RETURN);
    assign stack_err = err_q;

    always_ff @(posedge clk) begin
        if (push) stack_q[sp_q] <= pc_inc;
    end

    // Circular buffer: a push when full overwrites the oldest entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else if (push) begin
            sp_q <= sp_q + 1'b1;
            if (cnt_q == (SP_W+1)'(STACK_DEPTH)) err_q <= 1'b1;
            else cnt_q <= cnt_q + 1'b1;
        end else if (pop) begin
            if (cnt_q == '0) begin
                err_q <= 1'b1;
            end else begin
                sp_q  <= sp_q - 1'b1;
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = (STACK_DEPTH > 0);
    assign stack_err  = 1'b0;
`endif

    always_comb begin
        pc_nxt = pc_inc;
        unique case (1'b1)
            op == OP_GOTO: pc_nxt = PC_W'(fld);
            op == OP_SKPZ: pc_nxt = pc_q + PC_W'(bus.zero_cur ? 2 : 1);
            op == OP_SKPC: pc_nxt = pc_q + PC_W'(bus.carry_cur ? 2 : 1);
`ifdef CALL_STACK_EN
            op == OP_CALL:   pc_nxt = PC_W'(fld);
            op == OP_RETURN: pc_nxt = (cnt_q == '0) ? '0 : stack_q[sp_q - 1'b1];
`endif
            default: pc_nxt = pc_inc;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = S_READ;
            S_READ:   state_d = S_EXEC;
            S_EXEC:   state_d = S_WB;
            S_WB: begin
                if (op == OP_HALT) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                    pc_d    = pc_nxt;
                end
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            res_q   <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (state_q == S_DECODE) ir_q <= prog_data;
            if (state_q == S_EXEC) begin
                res_q <= alu_res;
                c_q   <= alu_c;
                z_q   <= alu_z;
            end
        end
    end

endmodule
